// File: rtl/opb_register_simulink2ppc_status_if.sv
// OPB bus signals between the PowerPC-side master and the status register slave.
// The master drives the OPB_* request side; the slave returns the Sl_* response side.
interface opb_register_simulink2ppc_status_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_simulink2ppc_status.sv
// Fabric-to-PPC capture register with NEW/OVR/CNT status; one-cycle registered ack after a hit,
// followed by a dead cycle. No backpressure: user_valid captures unconditionally every strobe.
module opb_register_simulink2ppc_status #(
    parameter logic [31:0] C_BASEADDR   = 32'h01003400,
    parameter logic [31:0] C_HIGHADDR   = 32'h010034FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                                   OPB_Clk,
    input  logic                                   OPB_Rst_n,
    opb_register_simulink2ppc_status_if.slave      opb,
    input  logic [31:0]                            user_data_in,
    input  logic                                   user_valid
);

    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             data_q;
    logic                    new_q;
    logic                    ovr_q;
    logic [15:0]             cnt_q;
    logic                    ack_q;
    logic [C_OPB_DWIDTH-1:0] dbus_q;

    logic [C_OPB_AWIDTH-1:0] addr;
    logic [1:0]              word_sel;
    logic                    hit;
    logic                    take;
    logic                    data_rd;
    logic                    ctrl_clr;
    logic [C_OPB_DWIDTH-1:0] rd_val;

    assign addr     = opb.OPB_ABus;
    assign word_sel = opb.OPB_ABus[28:29];
    assign hit      = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Select is only honoured in IDLE, so a held select sees a dead cycle between acks.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_ACK;
                    take    = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_rd  = take && opb.OPB_RNW && (word_sel == 2'd0);
    assign ctrl_clr = take && !opb.OPB_RNW && (word_sel == 2'd2) &&
                      opb.OPB_BE[3] && opb.OPB_DBus[31];

    always_comb begin
        rd_val = '0;
        if (opb.OPB_RNW) begin
            case (word_sel)
                2'd0:    rd_val = data_q;
                2'd1:    rd_val = {cnt_q, 14'd0, ovr_q, new_q};
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ack_q  <= 1'b0;
            dbus_q <= '0;
        end else if (take) begin
            ack_q  <= 1'b1;
            dbus_q <= rd_val;
        end else begin
            ack_q  <= 1'b0;
            dbus_q <= '0;
        end
    end

    // A DATA read in the same edge as a capture consumes the old value, so it must not flag overrun.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data_q <= '0;
            new_q  <= 1'b0;
            ovr_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (user_valid) data_q <= user_data_in;

            if (user_valid)                new_q <= 1'b1;
            else if (data_rd || ctrl_clr)  new_q <= 1'b0;

            if (ctrl_clr)                            ovr_q <= 1'b0;
            else if (user_valid && new_q && !data_rd) ovr_q <= 1'b1;

            if (ctrl_clr)        cnt_q <= user_valid ? 16'd1 : 16'd0;
            else if (user_valid) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign opb.Sl_DBus    = dbus_q;
    assign opb.Sl_xferAck = ack_q;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    // Bits of the bus this register has no use for.
    logic unused_bits;
    assign unused_bits = ^{opb.OPB_seqAddr, opb.OPB_BE[0:2], opb.OPB_DBus[0:30]};

endmodule

// File: tb/tb_opb_register_simulink2ppc_status.sv
module tb_opb_register_simulink2ppc_status;

    localparam logic [31:0] BASE = 32'h01003400;
    localparam logic [31:0] HIGH = 32'h010034FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] user_data_in = '0;
    logic        user_valid = 1'b0;

    opb_register_simulink2ppc_status_if bus ();

    opb_register_simulink2ppc_status dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .opb          (bus),
        .user_data_in (user_data_in),
        .user_valid   (user_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model of the register contents.
    logic [31:0] m_data;
    logic        m_new, m_ovr;
    logic [15:0] m_cnt;

    typedef struct {
        int          kind;     // 0 = capture only, 1 = bus transfer
        logic [31:0] addr;
        bit          rnw;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          cv;
        logic [31:0] cd;
        bit          ack;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    task automatic check(string nm, string what, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %08h expected %08h", nm, what, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_data = '0; m_new = 1'b0; m_ovr = 1'b0; m_cnt = '0;
    endfunction

    function automatic logic [31:0] m_status();
        return {m_cnt, 14'd0, m_ovr, m_new};
    endfunction

    function automatic bit m_hit(logic [31:0] a);
        return (a >= BASE) && (a <= HIGH);
    endfunction

    function automatic void m_capture(logic [31:0] v);
        m_ovr  = m_ovr | m_new;
        m_new  = 1'b1;
        m_cnt  = m_cnt + 16'd1;
        m_data = v;
    endfunction

    // Read value is taken from the pre-transfer state; read/clear effects land before a same-edge capture.
    function automatic logic [31:0] m_xfer(logic [31:0] a, bit rnw, logic [3:0] be,
                                           logic [31:0] wd, bit cv, logic [31:0] cd);
        logic [31:0] rd;
        int          word;
        rd = '0;
        if (m_hit(a)) begin
            word = ((a - BASE) / 4) % 4;
            if (rnw) begin
                if (word == 0) begin
                    rd    = m_data;
                    m_new = 1'b0;
                end else if (word == 1) begin
                    rd = m_status();
                end
            end else if (word == 2 && be[0] && wd[0]) begin
                m_new = 1'b0; m_ovr = 1'b0; m_cnt = '0;
            end
        end
        if (cv) m_capture(cd);
        return rd;
    endfunction

    function automatic vec_t mk(int k, logic [31:0] a, bit rnw, logic [3:0] be, logic [31:0] wd,
                                bit cv, logic [31:0] cd, bit ack, logic [31:0] rd);
        vec_t v;
        v.kind = k; v.addr = a; v.rnw = rnw; v.be = be; v.wd = wd;
        v.cv = cv; v.cd = cd; v.ack = ack; v.rd = rd;
        return v;
    endfunction

    // Entered just after a falling edge; returns just after a falling edge.
    task automatic capture(logic [31:0] v);
        user_valid   = 1'b1;
        user_data_in = v;
        @(negedge clk);
        user_valid   = 1'b0;
    endtask

    task automatic xfer(string nm, logic [31:0] a, bit rnw, logic [3:0] be, logic [31:0] wd,
                        bit cv, logic [31:0] cd, bit exp_ack, logic [31:0] exp_rd);
        bus.OPB_ABus   = a;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = wd;
        bus.OPB_RNW    = rnw;
        bus.OPB_select = 1'b1;
        user_valid     = cv;
        user_data_in   = cd;
        @(negedge clk);
        bus.OPB_select = 1'b0;
        user_valid     = 1'b0;
        check(nm, "ack", {31'd0, bus.Sl_xferAck}, {31'd0, exp_ack});
        if (exp_ack) check(nm, "data", bus.Sl_DBus, exp_rd);
        @(negedge clk);
        check(nm, "ack after", {31'd0, bus.Sl_xferAck}, 32'd0);
        check(nm, "dbus after", bus.Sl_DBus, 32'd0);
    endtask

    initial begin
        logic [31:0] a, wd, cd, exp;
        logic [3:0]  be;
        bit          rnw, cv;

        bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0;
        bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
        m_reset();

        #1 rst_n = 1'b0;
        #2;
        check("reset", "ack", {31'd0, bus.Sl_xferAck}, 32'd0);
        check("reset", "dbus", bus.Sl_DBus, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        tbl.push_back(mk(0, 0,         0, 4'hF, 0,            0, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(1, BASE+4,    1, 4'hF, 0,            0, 0, 1, 32'h00010001));
        tbl.push_back(mk(1, BASE,      1, 4'hF, 0,            0, 0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(1, BASE+4,    1, 4'hF, 0,            0, 0, 1, 32'h00010000));
        tbl.push_back(mk(1, BASE+8,    0, 4'hF, 32'h1,        0, 0, 1, 0));
        tbl.push_back(mk(1, BASE+4,    1, 4'hF, 0,            0, 0, 1, 32'h00000000));
        tbl.push_back(mk(0, 0,         0, 4'hF, 0,            0, 32'h1, 0, 0));
        tbl.push_back(mk(0, 0,         0, 4'hF, 0,            0, 32'h2, 0, 0));
        tbl.push_back(mk(1, BASE+4,    1, 4'hF, 0,            0, 0, 1, 32'h00020003));
        tbl.push_back(mk(1, BASE,      1, 4'hF, 0,            0, 0, 1, 32'h00000002));
        tbl.push_back(mk(1, BASE+8,    0, 4'hF, 32'h1,        0, 0, 1, 0));
        tbl.push_back(mk(1, BASE+4,    1, 4'hF, 0,            0, 0, 1, 32'h00000000));
        tbl.push_back(mk(0, 0,         0, 4'hF, 0,            0, 32'hA, 0, 0));
        tbl.push_back(mk(1, BASE,      1, 4'hF, 0,            1, 32'hB, 1, 32'h0000000A));
        tbl.push_back(mk(1, BASE+4,    1, 4'hF, 0,            0, 0, 1, 32'h00020001));
        tbl.push_back(mk(1, BASE,      1, 4'hF, 0,            0, 0, 1, 32'h0000000B));
        tbl.push_back(mk(1, BASE,      0, 4'hF, 32'hFFFFFFFF, 0, 0, 1, 0));
        tbl.push_back(mk(1, BASE+4,    0, 4'hF, 32'hFFFFFFFF, 0, 0, 1, 0));
        tbl.push_back(mk(1, BASE+12,   0, 4'hF, 32'h1,        0, 0, 1, 0));
        tbl.push_back(mk(1, BASE,      1, 4'hF, 0,            0, 0, 1, 32'h0000000B));
        tbl.push_back(mk(1, BASE+8,    0, 4'hE, 32'h1,        0, 0, 1, 0));
        tbl.push_back(mk(1, BASE+8,    0, 4'hF, 32'hFFFFFFFE, 0, 0, 1, 0));
        tbl.push_back(mk(1, BASE+4,    1, 4'hF, 0,            0, 0, 1, 32'h00020000));
        tbl.push_back(mk(1, BASE+8,    1, 4'hF, 0,            0, 0, 1, 32'h00000000));
        tbl.push_back(mk(1, BASE+12,   1, 4'hF, 0,            0, 0, 1, 32'h00000000));
        tbl.push_back(mk(1, 32'h01003500, 1, 4'hF, 0,         0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h010033FC, 1, 4'hF, 0,         0, 0, 0, 0));
        tbl.push_back(mk(1, BASE+32'hF0, 1, 4'hF, 0,          0, 0, 1, 32'h0000000B));
        tbl.push_back(mk(1, BASE+8,    0, 4'hF, 32'h1,        1, 32'h55, 1, 0));
        tbl.push_back(mk(1, BASE+4,    1, 4'hF, 0,            0, 0, 1, 32'h00010001));
        tbl.push_back(mk(1, BASE+4,    1, 4'hF, 0,            1, 32'h66, 1, 32'h00010001));
        tbl.push_back(mk(1, BASE+4,    1, 4'hF, 0,            0, 0, 1, 32'h00020003));
        tbl.push_back(mk(1, BASE,      1, 4'hF, 0,            0, 0, 1, 32'h00000066));

        foreach (tbl[i]) begin
            if (tbl[i].kind == 0) begin
                capture(tbl[i].cd);
                m_capture(tbl[i].cd);
            end else begin
                exp = m_xfer(tbl[i].addr, tbl[i].rnw, tbl[i].be, tbl[i].wd, tbl[i].cv, tbl[i].cd);
                xfer($sformatf("vec%0d", i), tbl[i].addr, tbl[i].rnw, tbl[i].be, tbl[i].wd,
                     tbl[i].cv, tbl[i].cd, tbl[i].ack, tbl[i].rd);
            end
        end

        // Held select: acks alternate with dead cycles.
        bus.OPB_ABus = BASE + 4; bus.OPB_RNW = 1'b1; bus.OPB_BE = 4'hF; bus.OPB_select = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold", $sformatf("ack c%0d", i), {31'd0, bus.Sl_xferAck}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("hold", $sformatf("dbus c%0d", i), bus.Sl_DBus, (i % 2 == 0) ? m_status() : 32'd0);
            check("hold", $sformatf("tieoffs c%0d", i),
                  {29'd0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
        end
        bus.OPB_select = 1'b0;
        @(negedge clk);
        check("hold", "ack released", {31'd0, bus.Sl_xferAck}, 32'd0);

        // Counter wrap.
        exp = m_xfer(BASE+8, 0, 4'hF, 32'h1, 0, 0);
        xfer("wrap clear", BASE+8, 0, 4'hF, 32'h1, 0, 0, 1, 0);
        user_valid = 1'b1; user_data_in = 32'h12345678;
        repeat (65536) @(negedge clk);
        user_valid = 1'b0;
        for (int i = 0; i < 65536; i++) m_capture(32'h12345678);
        exp = m_xfer(BASE+4, 1, 4'hF, 0, 0, 0);
        xfer("wrap", BASE+4, 1, 4'hF, 0, 0, 0, 1, 32'h00000003);
        capture(32'h9);
        m_capture(32'h9);
        exp = m_xfer(BASE+4, 1, 4'hF, 0, 0, 0);
        xfer("wrap+1", BASE+4, 1, 4'hF, 0, 0, 0, 1, 32'h00010003);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                cd = $urandom;
                capture(cd);
                m_capture(cd);
            end else begin
                case ($urandom_range(0, 7))
                    0:       a = HIGH + 32'd1 + ($urandom_range(0, 63) * 4);
                    1:       a = BASE - ($urandom_range(1, 16) * 4);
                    default: a = BASE + ($urandom_range(0, 15) * 16) + ($urandom_range(0, 3) * 4);
                endcase
                rnw = 1'($urandom_range(0, 1));
                be  = 4'($urandom);
                wd  = $urandom;
                if ($urandom_range(0, 1) == 1) wd[0] = 1'b1;
                cv  = 1'($urandom_range(0, 1));
                cd  = $urandom;
                exp = m_xfer(a, rnw, be, wd, cv, cd);
                xfer($sformatf("rand%0d", i), a, rnw, be, wd, cv, cd, m_hit(a), exp);
            end
        end
        exp = m_status();
        xfer("rand final status", BASE+4, 1, 4'hF, 0, 0, 0, 1, exp);

        // Reset during the ack cycle.
        bus.OPB_ABus = BASE + 4; bus.OPB_RNW = 1'b1; bus.OPB_BE = 4'hF; bus.OPB_select = 1'b1;
        @(negedge clk);
        bus.OPB_select = 1'b0;
        check("rst mid-ack", "ack before", {31'd0, bus.Sl_xferAck}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst mid-ack", "ack", {31'd0, bus.Sl_xferAck}, 32'd0);
        check("rst mid-ack", "dbus", bus.Sl_DBus, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        xfer("post-rst status", BASE+4, 1, 4'hF, 0, 0, 0, 1, 32'h00000000);
        xfer("post-rst data", BASE, 1, 4'hF, 0, 0, 0, 1, 32'h00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
